// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
// Bubbles are inserted on flush, load-use stall, or an invalid decode slot.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alusrc,
    input  logic [3:0]        id_cnrl,
    input  logic [4:0]        id_shamt,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,

    input  logic              flush,

    input  logic              exm_regwrite,
    input  logic [4:0]        exm_rd,
    input  logic [DATA_W-1:0] exm_data,
    input  logic              mwb_regwrite,
    input  logic [4:0]        mwb_rd,
    input  logic [DATA_W-1:0] mwb_data,

    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [3:0]        cnrl,
    output logic [4:0]        shamt,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              stall
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              alusrc;
        logic [3:0]        cnrl;
        logic [4:0]        shamt;
        logic [4:0]        rd;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d;
    logic    bubble;
    logic    rs_hit, rt_hit;
    logic [DATA_W-1:0] fa, fb;

    // Load-use: the load in EX cannot supply its data until after MEM.
    always_comb begin
        rs_hit = (ex_q.rd == id_rs);
        rt_hit = (ex_q.rd == id_rt);
        stall  = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_valid & (rs_hit | rt_hit);
    end

    assign bubble = flush | stall | ~id_valid;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.memwrite = id_memwrite;
            ex_d.alusrc   = id_alusrc;
            ex_d.cnrl     = id_cnrl;
            ex_d.shamt    = id_shamt;
            ex_d.rd       = id_rd;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.rs_data  = id_rs_data;
            ex_d.rt_data  = id_rt_data;
            ex_d.imm      = id_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM has the younger result, so it takes priority; r0 is never forwarded.
    always_comb begin
        fa = ex_q.rs_data;
        if (exm_regwrite && (exm_rd != 5'd0) && (exm_rd == ex_q.rs)) begin
            fa = exm_data;
        end else if (mwb_regwrite && (mwb_rd != 5'd0) && (mwb_rd == ex_q.rs)) begin
            fa = mwb_data;
        end

        fb = ex_q.rt_data;
        if (exm_regwrite && (exm_rd != 5'd0) && (exm_rd == ex_q.rt)) begin
            fb = exm_data;
        end else if (mwb_regwrite && (mwb_rd != 5'd0) && (mwb_rd == ex_q.rt)) begin
            fb = mwb_data;
        end
    end

    assign a             = fa;
    assign b             = ex_q.alusrc ? ex_q.imm : fb;
    assign ex_store_data = fb;
    assign cnrl          = ex_q.cnrl;
    assign shamt         = ex_q.shamt;
    assign ex_valid      = ex_q.valid;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_memread    = ex_q.memread;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: capture, forwarding, load-use, flush, reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alusrc;
    logic [3:0]  id_cnrl;
    logic [4:0]  id_shamt;
    logic        id_regwrite, id_memread, id_memwrite;
    logic        flush;
    logic        exm_regwrite;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        mwb_regwrite;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
    logic [31:0] a, b, ex_store_data;
    logic [3:0]  cnrl;
    logic [4:0]  shamt, ex_rd;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_cnrl(id_cnrl), .id_shamt(id_shamt),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .flush(flush),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .a(a), .b(b), .cnrl(cnrl), .shamt(shamt),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alusrc = 0;
        id_cnrl = 0; id_shamt = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    endtask

    task automatic fwd_clear();
        exm_regwrite = 0; exm_rd = 0; exm_data = 0;
        mwb_regwrite = 0; mwb_rd = 0; mwb_data = 0;
    endtask

    initial begin
        rst_n = 0; flush = 0;
        id_clear(); fwd_clear();
        #12;
        check("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        check("rst_a", a, 32'h0);
        check("rst_b", b, 32'h0);
        check("rst_store", ex_store_data, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_cnrl", {28'b0, cnrl}, 32'h0);
        #1 rst_n = 1;

        // Plain capture
        id_valid = 1; id_rs = 3; id_rs_data = 32'h5; id_rt = 4; id_rt_data = 32'h7;
        id_cnrl = 4'b0010; id_rd = 10; id_regwrite = 1; id_shamt = 5'd3;
        step();
        check("cap_a", a, 32'h5);
        check("cap_b", b, 32'h7);
        check("cap_cnrl", {28'b0, cnrl}, 32'h2);
        check("cap_shamt", {27'b0, shamt}, 32'h3);
        check("cap_valid", {31'b0, ex_valid}, 32'h1);
        check("cap_rd", {27'b0, ex_rd}, 32'd10);
        check("cap_regwrite", {31'b0, ex_regwrite}, 32'h1);

        // Double forward priority
        id_clear();
        id_valid = 1; id_rs = 8; id_rt = 8; id_rs_data = 32'h11; id_rt_data = 32'h22; id_rd = 12;
        step();
        exm_regwrite = 1; exm_rd = 8; exm_data = 32'hAA;
        mwb_regwrite = 1; mwb_rd = 8; mwb_data = 32'hBB;
        #1;
        check("fwd_exm_a", a, 32'hAA);
        check("fwd_exm_b", b, 32'hAA);
        check("fwd_exm_store", ex_store_data, 32'hAA);
        exm_regwrite = 0;
        #1;
        check("fwd_mwb_a", a, 32'hBB);
        check("fwd_mwb_b", b, 32'hBB);
        mwb_regwrite = 0;
        #1;
        check("fwd_none_a", a, 32'h11);
        check("fwd_none_b", b, 32'h22);
        fwd_clear();

        // Immediate operand with forwarded store data
        id_clear();
        id_valid = 1; id_alusrc = 1; id_imm = 32'hFFFF_FFFC; id_rs = 1; id_rs_data = 32'h100;
        id_rt = 5; id_rt_data = 32'h9; id_memwrite = 1;
        step();
        mwb_regwrite = 1; mwb_rd = 5; mwb_data = 32'h1234;
        #1;
        check("imm_b", b, 32'hFFFF_FFFC);
        check("imm_store", ex_store_data, 32'h1234);
        check("imm_a", a, 32'h100);
        check("imm_memwrite", {31'b0, ex_memwrite}, 32'h1);
        fwd_clear();

        // Load-use hazard
        id_clear();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd = 9; id_rs = 2; id_rs_data = 32'h40;
        step();
        check("lw_memread", {31'b0, ex_memread}, 32'h1);
        id_clear();
        id_valid = 1; id_rs = 9; id_rs_data = 32'h77; id_rt = 3; id_rt_data = 32'h33;
        id_regwrite = 1; id_rd = 4; id_cnrl = 4'b0001;
        #1;
        check("lu_stall", {31'b0, stall}, 32'h1);
        id_valid = 0;
        #1;
        check("lu_stall_novalid", {31'b0, stall}, 32'h0);
        id_valid = 1;
        step();
        check("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
        check("lu_bubble_regwrite", {31'b0, ex_regwrite}, 32'h0);
        check("lu_bubble_a", a, 32'h0);
        check("lu_stall_clear", {31'b0, stall}, 32'h0);
        step();
        check("lu_capture_valid", {31'b0, ex_valid}, 32'h1);
        check("lu_capture_a", a, 32'h77);
        check("lu_capture_rd", {27'b0, ex_rd}, 32'd4);

        // Load to r0 never stalls
        id_clear();
        id_valid = 1; id_memread = 1; id_rd = 0;
        step();
        id_clear();
        id_valid = 1; id_rs = 0;
        #1;
        check("lw_r0_nostall", {31'b0, stall}, 32'h0);

        // r0 never forwarded, then flush
        id_clear();
        id_valid = 1; id_rs = 0; id_rt = 0; id_cnrl = 4'b0101;
        step();
        exm_regwrite = 1; exm_rd = 0; exm_data = 32'hDEAD;
        #1;
        check("r0_a", a, 32'h0);
        check("r0_b", b, 32'h0);
        fwd_clear();
        id_clear();
        id_valid = 1; id_cnrl = 4'b0111; id_rs = 6; id_rs_data = 32'h66; flush = 1;
        step();
        check("flush_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_cnrl", {28'b0, cnrl}, 32'h0);
        check("flush_a", a, 32'h0);
        flush = 0;

        // Flush together with stall: one bubble, then re-presented capture
        id_clear();
        id_valid = 1; id_memread = 1; id_rd = 9;
        step();
        id_clear();
        id_valid = 1; id_rt = 9; id_rt_data = 32'h99; flush = 1;
        #1;
        check("fs_stall", {31'b0, stall}, 32'h1);
        step();
        check("fs_bubble", {31'b0, ex_valid}, 32'h0);
        flush = 0;
        step();
        check("fs_capture_valid", {31'b0, ex_valid}, 32'h1);
        check("fs_capture_b", b, 32'h99);

        // Asynchronous reset between edges
        id_clear();
        id_valid = 1; id_rs = 3; id_rs_data = 32'h5; id_rt = 4; id_rt_data = 32'h7;
        step();
        check("ar_pre_valid", {31'b0, ex_valid}, 32'h1);
        #2 rst_n = 0;
        #1;
        check("ar_valid", {31'b0, ex_valid}, 32'h0);
        check("ar_a", a, 32'h0);
        check("ar_b", b, 32'h0);
        check("ar_stall", {31'b0, stall}, 32'h0);
        #3 rst_n = 1;
        step();
        check("ar_post_valid", {31'b0, ex_valid}, 32'h1);
        check("ar_post_a", a, 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 ID_VALID  input  1  decode stage presents a valid instruction.
REQ-005 ID_RS, ID_RT, ID_RD  input  5 each  source/destination register indices.
REQ-006 ID_RS_DATA, ID_RT_DATA, ID_IMM  input  32 each  register-file reads; pre-extended immediate.
REQ-007 ID_ALUSRC  input  1  1 = B operand from immediate, 0 = from rt.
REQ-008 ID_CNRL  input  4  ALU opcode; ID_SHAMT  input  5  shift amount.
REQ-009 ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE  input  1 each  decode control bits.
REQ-010 FLUSH  input  1  squash the instruction being captured (branch/jump redirect).
REQ-011 EXM_REGWRITE  input  1; EXM_RD  input  5; EXM_DATA  input  32  EX/MEM forwarding source.
REQ-012 MWB_REGWRITE  input  1; MWB_RD  input  5; MWB_DATA  input  32  MEM/WB forwarding source.
REQ-013 A, B  output  32  ALU operands; CNRL  output  4; SHAMT  output  5.
REQ-014 EX_VALID, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE  output  1 each  registered controls.
REQ-015 EX_RD  output  5; EX_STORE_DATA  output  32  forwarded rt for stores.
REQ-016 STALL  output  1  load-use hazard; upstream holds PC and IF/ID when 1.

Function
REQ-017 Pipeline register SHALL capture all ID_* fields on every rising CLK edge; one-cycle latency ID to EX.
REQ-018 STALL SHALL be combinational: 1 iff EX_VALID & EX_MEMREAD & EX_RD!=0 & ID_VALID & (EX_RD==ID_RS | EX_RD==ID_RT).
REQ-019 Bubble SHALL be captured when FLUSH=1, STALL=1, or ID_VALID=0: EX_VALID, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, CNRL, SHAMT, EX_RD, stored rs/rt indices, data and immediate all loaded with 0.
REQ-020 FLUSH and STALL together SHALL produce one bubble; STALL is not masked by FLUSH.
REQ-021 Forwarded rs (fa) SHALL be: EXM_DATA if EXM_REGWRITE & EXM_RD!=0 & EXM_RD==stored rs; else MWB_DATA if MWB_REGWRITE & MWB_RD!=0 & MWB_RD==stored rs; else stored rs data.
REQ-022 Forwarded rt (fb) SHALL use identical priority against stored rt; EX/MEM always wins over MEM/WB.
REQ-023 Register 0 SHALL never be forwarded; stored index 0 always yields stored data.
REQ-024 A SHALL equal fa; B SHALL equal stored immediate if stored ALUSRC=1, else fb; EX_STORE_DATA SHALL equal fb regardless of ALUSRC.
REQ-025 Forwarding muxes SHALL be combinational on registered state plus EXM_*/MWB_* inputs (zero-cycle path into ALU).
REQ-026 CNRL and SHAMT SHALL be passed unmodified; invalid opcodes are not filtered here.
REQ-027 A stalled instruction SHALL be re-presented by upstream and captured on the first cycle STALL=0; exactly one bubble per load-use.

Reset
REQ-028 RST_N low SHALL asynchronously clear all registered state to 0: EX_VALID=0, all controls 0, CNRL=0000, SHAMT=0, EX_RD=0, stored data 0.
REQ-029 During and after reset, A, B, EX_STORE_DATA SHALL read 0 (stored indices 0 block forwarding); STALL=0.
REQ-030 Reset assertion mid-stall SHALL clear state immediately; first post-reset edge captures ID normally.

Verification
REQ-031 Plain capture: ID rs=3 data 0x5, rt=4 data 0x7, CNRL=0010, ALUSRC=0, no forwards -> next cycle A=0x5, B=0x7, CNRL=0010, EX_VALID=1.
REQ-032 Double forward: stored rs=rt=8; EXM_RD=8 data 0xAA, MWB_RD=8 data 0xBB, both REGWRITE -> A=B=0xAA; drop EXM_REGWRITE -> A=B=0xBB.
REQ-033 Load-use: EX holds lw to r9 (MEMREAD=1); ID rs=9 -> STALL=1, next cycle EX_VALID=0, EX_REGWRITE=0; ID re-presented -> captured, STALL=0.
REQ-034 Immediate/store: stored ALUSRC=1, imm 0xFFFFFFFC, rt=5 forwarded from MWB 0x1234, MEMWRITE=1 -> B=0xFFFFFFFC, EX_STORE_DATA=0x1234.
REQ-035 r0 and flush: EXM_RD=0 REGWRITE=1 data 0xDEAD, stored rs=0 data 0 -> A=0; FLUSH=1 at capture -> EX_VALID=0, CNRL=0000.
REQ-036 Async reset: RST_N low between clock edges with EX_VALID=1 -> EX_VALID, A, B drop to 0 without a clock edge.
